// File: rtl/mod_acc_pkg.sv
// Shared definitions for the modular accumulator sequencer:
// state encoding and default datapath widths.
package mod_acc_pkg;

    localparam int BITWIDTH_DEF = 16;
    localparam int LENW_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/mod_adder_reg.sv
// Registered modular adder: oData <= (iData0 + iData1) mod iQ when enabled.
// Inputs are assumed already reduced (< iQ), so one conditional subtract suffices.
module mod_adder_reg
    import mod_acc_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEF
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    input  logic [BITWIDTH-1:0] iData0,
    input  logic [BITWIDTH-1:0] iData1,
    input  logic [BITWIDTH-1:0] iQ,
    output logic [BITWIDTH-1:0] oData
);

    logic [BITWIDTH:0]   w_sum;
    logic [BITWIDTH:0]   w_diff;
    logic [BITWIDTH-1:0] w_res;
    logic [BITWIDTH-1:0] r_acc;

    // Carry bit kept so wide operands near Q do not lose the overflow.
    assign w_sum  = {1'b0, iData0} + {1'b0, iData1};
    assign w_diff = w_sum - {1'b0, iQ};
    assign w_res  = (w_sum < {1'b0, iQ}) ? w_sum[BITWIDTH-1:0] : w_diff[BITWIDTH-1:0];

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_acc <= '0;
        end else if (iClr) begin
            r_acc <= '0;
        end else if (iEn) begin
            r_acc <= w_res;
        end
    end

    assign oData = r_acc;

endmodule

// File: rtl/mod_acc_seq.sv
// Sequencer that folds L streamed operands into a mod-Q accumulator and
// hands the final residue to a valid/ready consumer.
module mod_acc_seq
    import mod_acc_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEF,
    parameter int LENW     = LENW_DEF
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic [LENW-1:0]     iLen,
    input  logic [BITWIDTH-1:0] iQ,
    input  logic                iInValid,
    output logic                oInReady,
    input  logic [BITWIDTH-1:0] iInData,
    output logic                oOutValid,
    input  logic                iOutReady,
    output logic [BITWIDTH-1:0] oOutData,
    output logic                oBusy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LENW-1:0]     r_cnt;
    logic [LENW-1:0]     r_len;
    logic [BITWIDTH-1:0] r_q;
    logic [BITWIDTH-1:0] w_acc;
    logic                w_en;
    logic                w_clr;
    logic                w_last;

    assign w_last = (r_cnt == r_len - LENW'(1));

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_q     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && iStart) begin
                r_len <= iLen;
                r_q   <= iQ;
                r_cnt <= '0;
            end else if (w_en) begin
                r_cnt <= r_cnt + LENW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_en        = 1'b0;
        w_clr       = iRst;
        oInReady    = 1'b0;
        oOutValid   = 1'b0;
        oOutData    = '0;
        oBusy       = 1'b1;
        case (r_state)
            IDLE: begin
                oBusy = 1'b0;
                if (iStart) begin
                    w_clr       = 1'b1;
                    w_state_nxt = (iLen == '0) ? OUT : ACC;
                end
            end
            ACC: begin
                oInReady = 1'b1;
                w_en     = iInValid;
                if (iInValid && w_last) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                oOutValid = 1'b1;
                oOutData  = w_acc;
                // Clearing on the accepting edge leaves IDLE with a zeroed accumulator.
                if (iOutReady) begin
                    w_clr       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    mod_adder_reg #(
        .BITWIDTH(BITWIDTH)
    ) u_adder (
        .iClk  (iClk),
        .iRstN (1'b1),
        .iEn   (w_en),
        .iClr  (w_clr),
        .iData0(w_acc),
        .iData1(iInData),
        .iQ    (r_q),
        .oData (w_acc)
    );

endmodule

// File: tb/tb_mod_acc_seq.sv
// Directed bench for mod_acc_seq: a job-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_mod_acc_seq;

    localparam int BW = 16;
    localparam int LW = 8;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic          iStart = 1'b0;
    logic [LW-1:0] iLen = '0;
    logic [BW-1:0] iQ = '0;
    logic          iInValid = 1'b0;
    logic          oInReady;
    logic [BW-1:0] iInData = '0;
    logic          oOutValid;
    logic          iOutReady = 1'b0;
    logic [BW-1:0] oOutData;
    logic          oBusy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    mod_acc_seq #(.BITWIDTH(BW), .LENW(LW)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iStart   (iStart),
        .iLen     (iLen),
        .iQ       (iQ),
        .iInValid (iInValid),
        .oInReady (oInReady),
        .iInData  (iInData),
        .oOutValid(oOutValid),
        .iOutReady(iOutReady),
        .oOutData (oOutData),
        .oBusy    (oBusy)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: phase 0 idle, 1 collecting operands, 2 presenting result.
    int m_phase = 0;
    int m_left  = 0;
    int m_q     = 1;
    int m_acc   = 0;

    always @(posedge iClk) begin
        if (iRst) begin
            m_phase = 0;
            m_acc   = 0;
        end else begin
            case (m_phase)
                0: if (iStart) begin
                    m_q     = int'(iQ);
                    m_left  = int'(iLen);
                    m_acc   = 0;
                    m_phase = (iLen == 0) ? 2 : 1;
                end
                1: if (iInValid) begin
                    m_acc  = (m_acc + int'(iInData)) % m_q;
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (iOutReady) m_phase = 0;
            endcase
        end
    end

    always @(negedge iClk) begin
        if (chk_en) begin
            chk("model_busy",     32'(oBusy),     32'(m_phase != 0));
            chk("model_inready",  32'(oInReady),  32'(m_phase == 1));
            chk("model_outvalid", 32'(oOutValid), 32'(m_phase == 2));
            chk("model_outdata",  32'(oOutData),  (m_phase == 2) ? 32'(m_acc) : 32'd0);
        end
    end

    task automatic tick();
        @(posedge iClk);
        #2;
    endtask

    task automatic start_job(input int len, input int q);
        iStart = 1'b1;
        iLen   = LW'(len);
        iQ     = BW'(q);
        tick();
        iStart = 1'b0;
    endtask

    task automatic send(input int x, input int bubbles);
        int n = 0;
        iInValid = 1'b0;
        repeat (bubbles) tick();
        while (!oInReady && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("send_timeout", 32'(oInReady), 32'd1);
        iInValid = 1'b1;
        iInData  = BW'(x);
        tick();
        iInValid = 1'b0;
    endtask

    task automatic take_result(input string name, input int exp, input int hold);
        int n = 0;
        while (!oOutValid && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_valid"}, 32'(oOutValid), 32'd1);
        chk({name, "_data"}, 32'(oOutData), 32'(exp));
        iOutReady = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({name, "_hold"}, 32'(oOutData), 32'(exp));
            chk({name, "_inrdy_out"}, 32'(oInReady), 32'd0);
        end
        iOutReady = 1'b1;
        tick();
        iOutReady = 1'b0;
        chk({name, "_idle"}, 32'(oBusy), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        chk("rst_busy",     32'(oBusy),     32'd0);
        chk("rst_inready",  32'(oInReady),  32'd0);
        chk("rst_outvalid", 32'(oOutValid), 32'd0);
        chk("rst_outdata",  32'(oOutData),  32'd0);
        iRst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Basic fold: 10, 9, 16 mod 17 -> 1, valid after the third accept.
        start_job(3, 17);
        send(10, 0);
        send(9, 0);
        chk("fold_not_yet", 32'(oOutValid), 32'd0);
        send(16, 0);
        chk("fold_latency", 32'(oOutValid), 32'd1);
        take_result("fold", 1, 0);

        // Wide reduction near 2^16.
        start_job(2, 65521);
        send(65520, 0);
        send(65520, 0);
        take_result("wide", 65519, 0);

        // Flow control with input bubbles and a stalled consumer.
        start_job(4, 97);
        send(50, 2);
        send(60, 1);
        send(70, 3);
        send(80, 2);
        take_result("flow", 66, 5);

        // Zero length goes straight to output.
        start_job(0, 23);
        chk("zero_valid",   32'(oOutValid), 32'd1);
        chk("zero_inready", 32'(oInReady),  32'd0);
        take_result("zero", 0, 1);

        // Start pulse mid-job is ignored.
        start_job(2, 13);
        send(12, 0);
        iStart = 1'b1;
        iLen   = LW'(5);
        iQ     = BW'(7);
        tick();
        iStart = 1'b0;
        send(5, 0);
        take_result("ignstart", 4, 0);

        // Reset mid-job aborts and leaves no stale accumulator.
        start_job(4, 17);
        send(5, 0);
        send(6, 0);
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        chk("midrst_busy",     32'(oBusy),     32'd0);
        chk("midrst_outvalid", 32'(oOutValid), 32'd0);
        chk("midrst_inready",  32'(oInReady),  32'd0);
        chk("midrst_outdata",  32'(oOutData),  32'd0);
        start_job(1, 17);
        send(3, 0);
        take_result("postrst", 3, 0);

        // Maximum length: 255 x 200 mod 251 = 47, no counter wrap.
        start_job(255, 251);
        for (int i = 0; i < 255; i++) send(200, 0);
        take_result("maxlen", 47, 0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_acc_seq.md
Name: mod_acc_seq

Overview:
Sequencer that drives one modular adder-register (`mod_adder_reg`) as a modular accumulator. A job is started with a length L and modulus Q. The block accepts L operands over a valid/ready input stream and folds each one into acc = (acc + x) mod Q. It then presents the final residue on a valid/ready output stream. It sits between an operand source (NTT/RNS front end) and a result consumer, and owns all enable/clear sequencing of the adder.

Parameters:
BITWIDTH, 16, operand/modulus/result width
LENW, 8, width of job length field (max L = 2^LENW-1)

Ports:
iClk  in  1  clock
iRst  in  1  reset, synchronous, active-high
iStart  in  1  start pulse; sampled only in IDLE
iLen  in  LENW  operand count L for the job
iQ  in  BITWIDTH  modulus; latched at start
iInValid  in  1  operand valid
oInReady  out  1  operand ready
iInData  in  BITWIDTH  operand, must be < Q
oOutValid  out  1  result valid
iOutReady  in  1  result ready
oOutData  out  BITWIDTH  result residue
oBusy  out  1  high in every state except IDLE

Behaviour:
- One clock (iClk). Reset is synchronous and active-high (iRst).
- On reset:
  - state = IDLE.
  - Outputs: oInReady = 0, oOutValid = 0, oOutData = 0, oBusy = 0.
  - Length counter = 0, latched Q = 0.
  - The adder instance is cleared through its iClr input. Its iRstN is tied high, so the only reset path is synchronous.
- IDLE:
  - iStart = 1 and iLen != 0: latch Q and L, clear the accumulator (iClr = 1 this cycle), counter = 0, go to ACC next cycle.
  - iStart = 1 and iLen == 0: clear the accumulator, go to OUT. The result is 0.
- ACC:
  - oInReady = 1.
  - An operand is taken when iInValid & oInReady; adder iEn = 1 only on that cycle, and counter += 1.
  - The accumulator holds its value on bubbles (iInValid = 0).
  - When the operand taken is the L-th (counter == L-1 at the handshake), go to OUT next cycle.
- OUT:
  - oOutValid = 1, oOutData = accumulator value.
  - Both must stay stable while iOutReady = 0.
  - On iOutReady = 1, go to IDLE next cycle. oOutValid drops and the accumulator is cleared.
- Timing:
  - Accumulator update latency is 1 cycle after each handshake.
  - The first cycle of OUT already shows the final residue.
  - Minimum job time is L + 2 cycles (start, L accepts, 1 output cycle with immediate ready).
- Arithmetic:
  - Sum is formed BITWIDTH+1 bits wide.
  - Result = sum < Q ? sum : sum - Q, truncated to BITWIDTH.
  - The result is correct only if acc < Q and x < Q. Operands >= Q are a caller error; no check, result undefined.
  - Q = 0 is illegal.
- Boundary and priority rules:
  - iStart outside IDLE is ignored; a new job needs a fresh pulse in IDLE.
  - iQ/iLen changes after start have no effect until the next start.
  - L = 2^LENW-1 must complete without counter wrap.
  - iRst has priority over everything, mid-job included: it aborts the job, drops any pending output and returns to IDLE in one cycle.
  - oInReady and oOutValid are never high in the same cycle.

Decomposition:
- Package mod_acc_pkg:
  - state encoding constants: IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2.
  - default widths BITWIDTH/LENW.
- Sub-module: instantiate the existing `mod_adder_reg` as the accumulator datapath.
  - iData0 = accumulator output, iData1 = iInData, iQ = latched Q.
  - iEn and iClr are driven by the FSM.
- The FSM, counter and handshake logic live in mod_acc_seq.

Test Plan:
- Basic fold: Q=17, L=3, operands 10, 9, 16 back-to-back -> oOutValid=1 in cycle 5 after start, oOutData=1 (10, 2, 1).
- Wide reduction: BITWIDTH=16, Q=65521, L=2, operands 65520, 65520 -> oOutData=65519. No overflow loss in the 17-bit sum.
- Flow control:
  - Q=97, L=4, operands 50,60,70,80.
  - iInValid bubbles between operands and iOutReady held 0 for 5 cycles -> oOutData=66 stable throughout.
  - oInReady=0 during OUT; IDLE follows the cycle after iOutReady=1.
- Zero length: iStart with iLen=0 -> OUT next cycle, oOutData=0; no input handshake occurs.
- Ignored start: Q=13, L=2. Pulse iStart with iLen=5, iQ=7 while in ACC -> job still ends after 2 operands with mod 13: operands 12,5 -> 4.
- Reset mid-job: iRst=1 after the 2nd of 4 operands -> next cycle oBusy=0, oOutValid=0, oInReady=0, oOutData=0. A subsequent job with Q=17, L=1, operand 3 returns 3 (no stale accumulator).
